// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control sequencer (IF/ID/EXE/MEM/WB).
// Drives PC/IR write enables, memory and register-file write strobes and the
// datapath mux selects. IF and MEM stall while mem_rdy is low.
// Only state, illegal and icount are registered; every other output is
// decoded combinationally from the current state and the inputs.
// Optional feature: define MC_CTRL_ICOUNT_EN to build the retired-instruction
// counter on icount; without it icount is tied to zero.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             z,
    input  logic             mem_rdy,
    output logic             wpc,
    output logic             wir,
    output logic             wmem,
    output logic             wreg,
    output logic             iord,
    output logic [1:0]       pcsource,
    output logic             regdst,
    output logic             m2reg,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    state_t state_q;
    state_t state_d;

    // Instruction decode from the IR fields.
    logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_j;
    logic func_ok, legal;

    assign is_rtype = (op == OP_RTYPE);
    assign is_addi  = (op == OP_ADDI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_j     = (op == OP_J);

    assign func_ok = (func == 6'b100000) || (func == 6'b100010) ||
                     (func == 6'b100100) || (func == 6'b100101);

    assign legal = (is_rtype && func_ok) || is_addi || is_lw ||
                   is_sw || is_beq || is_j;

    // Ungated decode results; gated by Clrn before reaching the ports.
    logic       wpc_c, wir_c, wmem_c, wreg_c, iord_c, regdst_c, m2reg_c;
    logic [1:0] pcsource_c;
    logic       set_illegal;

    // Next-state and output decode for every state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d     = S_IF;
        wpc_c       = 1'b0;
        wir_c       = 1'b0;
        wmem_c      = 1'b0;
        wreg_c      = 1'b0;
        iord_c      = 1'b0;
        pcsource_c  = PC_PLUS4;
        regdst_c    = 1'b0;
        m2reg_c     = 1'b0;
        set_illegal = 1'b0;

        case (state_q)
            S_IF: begin
                // Fetch from PC; wait for memory before loading PC and IR.
                if (mem_rdy) begin
                    wpc_c   = 1'b1;
                    wir_c   = 1'b1;
                    state_d = S_ID;
                end else begin
                    state_d = S_IF;
                end
            end

            S_ID: begin
                if (is_j) begin
                    wpc_c      = 1'b1;
                    pcsource_c = PC_JUMP;
                    state_d    = S_IF;
                end else if (!legal) begin
                    set_illegal = 1'b1;
                    state_d     = S_IF;
                end else begin
                    state_d = S_EXE;
                end
            end

            S_EXE: begin
                if (is_beq) begin
                    pcsource_c = PC_BRANCH;
                    wpc_c      = z;
                    state_d    = S_IF;
                end else if (is_rtype || is_addi) begin
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_IF;
                end
            end

            S_MEM: begin
                // Data access through the ALU-computed address.
                iord_c = 1'b1;
                if (!mem_rdy) begin
                    state_d = S_MEM;
                end else if (is_sw) begin
                    wmem_c  = 1'b1;
                    state_d = S_IF;
                end else if (is_lw) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IF;
                end
            end

            S_WB: begin
                wreg_c   = 1'b1;
                regdst_c = is_rtype;
                m2reg_c  = is_lw;
                state_d  = S_IF;
            end

            default: begin
                state_d = S_IF;
            end
        endcase
    end

    // NOTE: the port outputs are masked with Clrn because the decode is
    // combinational; without the mask, IF with mem_rdy=1 would raise wpc/wir
    // while the controller is held in reset.
    assign wpc      = wpc_c  & Clrn;
    assign wir      = wir_c  & Clrn;
    assign wmem     = wmem_c & Clrn;
    assign wreg     = wreg_c & Clrn;
    assign iord     = iord_c & Clrn;
    assign regdst   = regdst_c & Clrn;
    assign m2reg    = m2reg_c & Clrn;
    assign pcsource = Clrn ? pcsource_c : PC_PLUS4;
    assign state    = state_q;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge Clk or negedge Clrn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before this clock edge.
        if (!Clrn) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky unsupported-instruction flag, cleared only by reset.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            illegal <= 1'b0;
        end else if (set_illegal) begin
            illegal <= 1'b1;
        end
    end

`ifdef MC_CTRL_ICOUNT_EN
    // An instruction retires on any return to IF except an illegal ID.
    logic             retire;
    logic [CNT_W-1:0] icount_q;

    assign retire = (state_d == S_IF) && (state_q != S_IF) && !set_illegal;

    // Retired-instruction counter, wraps modulo 2^CNT_W.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            icount_q <= '0;
        end else if (retire) begin
            icount_q <= icount_q + CNT_W'(1);
        end
    end

    assign icount = icount_q;
`else
    assign icount = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized self-checking bench for mc_ctrl.
// For each instruction the reference model lists the expected per-cycle
// behaviour straight from the instruction-class rules (fetch stalls, decode,
// execute, memory stalls, write-back), then the bench replays that list
// against the DUT, driving inputs at the falling edge and checking just after.
module tb_mc_ctrl;

    localparam int CNT_W = 32;

    localparam logic [2:0] ST_IF  = 3'd0;
    localparam logic [2:0] ST_ID  = 3'd1;
    localparam logic [2:0] ST_EXE = 3'd2;
    localparam logic [2:0] ST_MEM = 3'd3;
    localparam logic [2:0] ST_WB  = 3'd4;

    logic             Clk;
    logic             Clrn;
    logic [5:0]       op;
    logic [5:0]       func;
    logic             z;
    logic             mem_rdy;
    logic             wpc, wir, wmem, wreg, iord, regdst, m2reg;
    logic [1:0]       pcsource;
    logic [2:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] icount;

    mc_ctrl #(.CNT_W(CNT_W)) dut (
        .Clk      (Clk),
        .Clrn     (Clrn),
        .op       (op),
        .func     (func),
        .z        (z),
        .mem_rdy  (mem_rdy),
        .wpc      (wpc),
        .wir      (wir),
        .wmem     (wmem),
        .wreg     (wreg),
        .iord     (iord),
        .pcsource (pcsource),
        .regdst   (regdst),
        .m2reg    (m2reg),
        .state    (state),
        .illegal  (illegal),
        .icount   (icount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One expected clock cycle: state, mem_rdy to drive, output bundle,
    // and whether the cycle retires or flags an illegal instruction.
    typedef struct {
        logic [2:0] st;
        logic       mr;
        logic [8:0] outs;
        bit         ret;
        bit         ill;
    } cyc_t;

    cyc_t        plan[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          ill_m   = 1'b0;
    logic [31:0] cnt_m   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output bundle order: wpc wir wmem wreg iord pcsource[1:0] regdst m2reg.
    function automatic logic [8:0] pk(bit p, bit i, bit m, bit r, bit a,
                                      logic [1:0] s, bit d, bit g);
        return {p, i, m, r, a, s, d, g};
    endfunction

    function automatic logic [8:0] dut_outs();
        return {wpc, wir, wmem, wreg, iord, pcsource, regdst, m2reg};
    endfunction

    function automatic logic [31:0] exp_icount();
`ifdef MC_CTRL_ICOUNT_EN
        return cnt_m;
`else
        return 32'd0;
`endif
    endfunction

    function automatic bit good_func(logic [5:0] f);
        return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25);
    endfunction

    function automatic bit known_op(logic [5:0] o);
        return (o == 6'h00) || (o == 6'h08) || (o == 6'h23) ||
               (o == 6'h2b) || (o == 6'h04) || (o == 6'h02);
    endfunction

    task automatic push(input logic [2:0] st, input logic mr, input logic [8:0] outs,
                        input bit ret, input bit ill);
        plan.push_back('{st: st, mr: mr, outs: outs, ret: ret, ill: ill});
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Build the expected cycle list for one instruction, then replay it.
    task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic zz,
                            input int if_st, input int mem_st);
        bit is_r, is_lw, is_sw, is_beq, is_j, bad;
        is_r   = (o == 6'h00);
        is_lw  = (o == 6'h23);
        is_sw  = (o == 6'h2b);
        is_beq = (o == 6'h04);
        is_j   = (o == 6'h02);
        bad    = !known_op(o) || (is_r && !good_func(f));
        plan.delete();

        for (int i = 0; i < if_st; i++) push(ST_IF, 1'b0, 9'd0, 0, 0);
        push(ST_IF, 1'b1, pk(1, 1, 0, 0, 0, 2'b00, 0, 0), 0, 0);

        if (is_j) begin
            push(ST_ID, rnd_bit(), pk(1, 0, 0, 0, 0, 2'b11, 0, 0), 1, 0);
        end else if (bad) begin
            push(ST_ID, rnd_bit(), 9'd0, 0, 1);
        end else begin
            push(ST_ID, rnd_bit(), 9'd0, 0, 0);
            if (is_beq) begin
                push(ST_EXE, rnd_bit(), pk(zz, 0, 0, 0, 0, 2'b01, 0, 0), 1, 0);
            end else begin
                push(ST_EXE, rnd_bit(), 9'd0, 0, 0);
                if (is_lw || is_sw) begin
                    for (int i = 0; i < mem_st; i++)
                        push(ST_MEM, 1'b0, pk(0, 0, 0, 0, 1, 2'b00, 0, 0), 0, 0);
                    push(ST_MEM, 1'b1, pk(0, 0, is_sw, 0, 1, 2'b00, 0, 0), is_sw, 0);
                end
                if (!is_sw)
                    push(ST_WB, rnd_bit(), pk(0, 0, 0, 1, 0, 2'b00, is_r, is_lw), 1, 0);
            end
        end

        foreach (plan[i]) begin
            op      = o;
            func    = f;
            z       = zz;
            mem_rdy = plan[i].mr;
            #1;
            check("state",   32'(state),      32'(plan[i].st));
            check("outputs", 32'(dut_outs()), 32'(plan[i].outs));
            check("illegal", 32'(illegal),    32'(ill_m));
            check("icount",  32'(icount),     exp_icount());
            if (plan[i].ill) ill_m = 1'b1;
            if (plan[i].ret) cnt_m = cnt_m + 32'd1;
            @(negedge Clk);
        end
    endtask

    task automatic rnd_instr();
        logic [5:0] o, f;
        int kind;
        kind = $urandom_range(0, 7);
        f    = 6'($urandom);
        case (kind)
            0: begin
                o = 6'h00;
                case ($urandom_range(0, 3))
                    0: f = 6'h20;
                    1: f = 6'h22;
                    2: f = 6'h24;
                    default: f = 6'h25;
                endcase
            end
            1: o = 6'h08;
            2: o = 6'h23;
            3: o = 6'h2b;
            4: o = 6'h04;
            5: o = 6'h02;
            6: begin
                o = 6'($urandom);
                while (known_op(o)) o = 6'($urandom);
            end
            default: o = 6'h00;
        endcase
        do_instr(o, f, rnd_bit(), $urandom_range(0, 2), $urandom_range(0, 2));
    endtask

    initial begin
        Clrn    = 1'b0;
        op      = 6'h00;
        func    = 6'h20;
        z       = 1'b0;
        mem_rdy = 1'b1;

        // Held in reset with mem_rdy high: nothing may be enabled.
        repeat (2) @(negedge Clk);
        #1;
        check("rst_state",   32'(state),      32'(ST_IF));
        check("rst_outputs", 32'(dut_outs()), 32'd0);
        check("rst_illegal", 32'(illegal),    32'd0);
        check("rst_icount",  32'(icount),     32'd0);
        @(negedge Clk);
        Clrn = 1'b1;

        // Directed sequences.
        do_instr(6'h00, 6'h20, 1'b0, 0, 0);  // add
        do_instr(6'h23, 6'h00, 1'b0, 0, 2);  // lw, 2 MEM stalls
        do_instr(6'h04, 6'h00, 1'b1, 0, 0);  // beq taken
        do_instr(6'h04, 6'h00, 1'b0, 0, 0);  // beq not taken
        do_instr(6'h2b, 6'h00, 1'b0, 0, 0);  // sw
        do_instr(6'h02, 6'h00, 1'b0, 0, 0);  // j
        do_instr(6'h08, 6'h00, 1'b0, 1, 0);  // addi, 1 IF stall

        // Reset in the middle of EXE, then release into a stalled fetch.
        op      = 6'h00;
        func    = 6'h20;
        z       = 1'b0;
        mem_rdy = 1'b1;
        repeat (2) @(negedge Clk);
        #1;
        check("pre_rst_state", 32'(state), 32'(ST_EXE));
        Clrn = 1'b0;
        #1;
        check("mid_rst_state",   32'(state),      32'(ST_IF));
        check("mid_rst_outputs", 32'(dut_outs()), 32'd0);
        check("mid_rst_icount",  32'(icount),     32'd0);
        ill_m = 1'b0;
        cnt_m = '0;
        @(negedge Clk);
        Clrn = 1'b1;
        do_instr(6'h00, 6'h20, 1'b0, 3, 0);

        // Unsupported op, then R-type with an unsupported func.
        do_instr(6'h3f, 6'h00, 1'b0, 0, 0);
        do_instr(6'h00, 6'h08, 1'b0, 0, 0);
        do_instr(6'h00, 6'h25, 1'b0, 0, 0);  // legal again, flag stays set

        // Random instruction stream.
        for (int n = 0; n < 200; n++) rnd_instr();

        // Reset clears the sticky flag and the counter.
        Clrn = 1'b0;
        #1;
        check("end_rst_illegal", 32'(illegal), 32'd0);
        check("end_rst_icount",  32'(icount),  32'd0);
        check("end_rst_state",   32'(state),   32'(ST_IF));
        @(negedge Clk);
        Clrn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
